// File: rtl/ddr2_read_data_unpack.sv
// DDR2 read-return capture FIFO, beat-to-word unpacker and read-credit tracker.
// Optional build macro DDR2_RD_BYTESWAP_EN byte-reverses every output word.
module ddr2_read_data_unpack #(
   parameter int unsigned APP_DW     = 128,
   parameter int unsigned OUT_DW     = 32,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_issued,
   input  logic [APP_DW-1:0]             app_rd_data,
   input  logic                          app_rd_data_valid,
   output logic                          credit_ok,
   output logic [OUT_DW-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   outstanding,
   output logic                          err_overflow,
   output logic                          err_underflow
);
   localparam int unsigned RATIO = APP_DW / OUT_DW;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

   typedef enum logic {StIdle, StShift} state_t;

   logic [APP_DW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr, r_rptr;
   logic [CW-1:0]     r_count, r_out;
   state_t            r_state, w_state_d;
   logic [APP_DW-1:0] r_shift, w_shift_d, w_shift_nx, w_head;
   logic [LW-1:0]     r_lane, w_lane_d;
   logic [OUT_DW-1:0] r_data, w_data_d;
   logic              r_valid, w_valid_d;
   logic              r_err_ovf, r_err_unf;
   logic              w_full, w_nempty, w_pop, w_wr;
   logic [CW:0]       w_sum;

   function automatic logic [OUT_DW-1:0] f_fmt(input logic [OUT_DW-1:0] i_w);
`ifdef DDR2_RD_BYTESWAP_EN
      logic [OUT_DW-1:0] w_r;
      w_r = '0;
      for (int b = 0; b < OUT_DW / 8; b++) begin
         w_r[8*b +: 8] = i_w[OUT_DW-8-8*b +: 8];
      end
      return w_r;
`else
      return i_w;
`endif
   endfunction

   assign w_full     = (r_count == DEPTH_C);
   assign w_nempty   = (r_count != '0);
   assign w_head     = r_mem[r_rptr];
   assign w_shift_nx = r_shift >> OUT_DW;
   // A pop in the same cycle frees the head slot, so a full FIFO still accepts the beat.
   assign w_wr       = app_rd_data_valid & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= app_rd_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_err_ovf <= 1'b0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         if (w_wr && !w_pop) r_count <= r_count + CW'(1);
         else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
         if (app_rd_data_valid && !w_wr) r_err_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out     <= '0;
         r_err_unf <= 1'b0;
      end else begin
         if (cmd_issued && !app_rd_data_valid) begin
            if (r_out != DEPTH_C) r_out <= r_out + CW'(1);
         end else if (app_rd_data_valid && !cmd_issued && r_out != '0) begin
            r_out <= r_out - CW'(1);
         end
         if (app_rd_data_valid && r_out == '0) r_err_unf <= 1'b1;
      end
   end

   assign w_sum     = {1'b0, r_out} + {1'b0, r_count};
   assign credit_ok = (w_sum < {1'b0, DEPTH_C});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_shift <= '0;
         r_lane  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_shift <= w_shift_d;
         r_lane  <= w_lane_d;
         r_data  <= w_data_d;
         r_valid <= w_valid_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_pop     = 1'b0;
      w_shift_d = r_shift;
      w_lane_d  = r_lane;
      w_data_d  = r_data;
      w_valid_d = r_valid;
      unique case (r_state)
         StIdle: begin
            if (w_nempty) begin
               w_pop     = 1'b1;
               w_shift_d = w_head;
               w_lane_d  = '0;
               w_data_d  = f_fmt(w_head[OUT_DW-1:0]);
               w_valid_d = 1'b1;
               w_state_d = StShift;
            end
         end
         StShift: begin
            if (out_ready) begin
               if (r_lane != LAST_LANE) begin
                  w_lane_d  = r_lane + LW'(1);
                  w_shift_d = w_shift_nx;
                  w_data_d  = f_fmt(w_shift_nx[OUT_DW-1:0]);
               end else if (w_nempty) begin
                  // Back-to-back beats: load the next head with no idle bubble.
                  w_pop     = 1'b1;
                  w_shift_d = w_head;
                  w_lane_d  = '0;
                  w_data_d  = f_fmt(w_head[OUT_DW-1:0]);
               end else begin
                  w_valid_d = 1'b0;
                  w_state_d = StIdle;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign out_data      = r_data;
   assign out_valid     = r_valid;
   assign outstanding   = r_out;
   assign err_overflow  = r_err_ovf;
   assign err_underflow = r_err_unf;
endmodule

// File: tb/tb_ddr2_read_data_unpack.sv
// Directed and randomized bench for ddr2_read_data_unpack; reference model is a word queue
// plus an outstanding-read count.
module tb_ddr2_read_data_unpack;
   logic         clk;
   logic         reset;
   logic         cmd_issued;
   logic [127:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         credit_ok;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   outstanding;
   logic         err_overflow;
   logic         err_underflow;

   int unsigned  total = 0;
   int unsigned  bad   = 0;
   int unsigned  m_out = 0;
   bit           m_push = 1'b1;
   logic [31:0]  exp_q[$];
   logic [127:0] beat_a;

   ddr2_read_data_unpack dut (
      .clk               (clk),
      .reset             (reset),
      .cmd_issued        (cmd_issued),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid),
      .credit_ok         (credit_ok),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .outstanding       (outstanding),
      .err_overflow      (err_overflow),
      .err_underflow     (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef DDR2_RD_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks any word handed over at the coming edge, updates the model, then advances one cycle.
   task automatic step();
      logic [31:0] w;
      if (out_valid && out_ready) begin
         chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("word", out_data, w);
         end
      end
      if (cmd_issued && !app_rd_data_valid && m_out < 8) m_out++;
      else if (app_rd_data_valid && !cmd_issued && m_out > 0) m_out--;
      if (app_rd_data_valid && m_push) begin
         for (int l = 0; l < 4; l++) exp_q.push_back(fmt(app_rd_data[32*l +: 32]));
      end
      @(posedge clk);
      #1;
      cmd_issued        = 1'b0;
      app_rd_data_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_idle"}, 32'(out_valid), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_q.delete();
      m_out = 0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      reset = 1'b0;
      cmd_issued = 1'b0;
      app_rd_data = '0;
      app_rd_data_valid = 1'b0;
      out_ready = 1'b0;
      beat_a = 128'h0000000D_0000000C_0000000B_0000000A;
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_outst", 32'(outstanding), 32'd0);
      chk("rst_credit", 32'(credit_ok), 32'd1);
      chk("rst_errs", {30'd0, err_overflow, err_underflow}, 32'd0);
      do_reset();

      // Single beat, consumer always ready
      out_ready = 1'b1;
      cmd_issued = 1'b1;
      step();
      chk("t1_outst1", 32'(outstanding), 32'd1);
      app_rd_data = beat_a;
      app_rd_data_valid = 1'b1;
      step();
      chk("t1_outst0", 32'(outstanding), 32'd0);
      chk("t1_lat_valid", 32'(out_valid), 32'd0);
      step();
      chk("t1_w0_valid", 32'(out_valid), 32'd1);
      chk("t1_w0", out_data, fmt(32'h0000000A));
      drain("t1");

      // Stalled consumer holds word 0 stable
      out_ready = 1'b0;
      cmd_issued = 1'b1;
      step();
      app_rd_data = beat_a;
      app_rd_data_valid = 1'b1;
      step();
      step();
      for (int i = 0; i < 10; i++) begin
         chk("t2_hold_valid", 32'(out_valid), 32'd1);
         chk("t2_hold_data", out_data, fmt(32'h0000000A));
         step();
      end
      drain("t2");

      // Credit exhaustion and return
      out_ready = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         cmd_issued = 1'b1;
         step();
         chk("t3_credit_cmd", 32'(credit_ok), 32'(n < 8));
      end
      chk("t3_outst8", 32'(outstanding), 32'd8);
      for (int j = 0; j < 8; j++) begin
         app_rd_data = {4{32'(j) + 32'h100}} + {32'd3, 32'd2, 32'd1, 32'd0};
         app_rd_data_valid = 1'b1;
         step();
         chk("t3_credit_beat", 32'(credit_ok), 32'(j != 0));
      end
      chk("t3_outst0", 32'(outstanding), 32'd0);
      chk("t3_errs", {30'd0, err_overflow, err_underflow}, 32'd0);
      drain("t3");

      // Simultaneous issue/return and unsolicited beat
      out_ready = 1'b1;
      cmd_issued = 1'b1;
      step();
      cmd_issued = 1'b1;
      step();
      chk("t4_outst2", 32'(outstanding), 32'd2);
      cmd_issued = 1'b1;
      app_rd_data = 128'h44_0000_0033_0000_0022_0000_0011;
      app_rd_data_valid = 1'b1;
      step();
      chk("t4_outst_same", 32'(outstanding), 32'd2);
      for (int j = 0; j < 2; j++) begin
         app_rd_data = {$urandom, $urandom, $urandom, $urandom};
         app_rd_data_valid = 1'b1;
         step();
      end
      chk("t4_outst_back0", 32'(outstanding), 32'(m_out));
      chk("t4_no_unf", 32'(err_underflow), 32'd0);
      drain("t4a");
      app_rd_data = {$urandom, $urandom, $urandom, $urandom};
      app_rd_data_valid = 1'b1;
      step();
      chk("t4_unf", 32'(err_underflow), 32'd1);
      chk("t4_unf_outst", 32'(outstanding), 32'd0);
      chk("t4_no_ovf", 32'(err_overflow), 32'd0);
      drain("t4b");

      // Overflow: one beat held by the unpacker, eight in the FIFO, the next is dropped
      do_reset();
      out_ready = 1'b0;
      for (int j = 0; j < 10; j++) begin
         m_push = (j < 9);
         app_rd_data = {4{$urandom}} ^ {32'd3, 32'd2, 32'd1, 32'(j)};
         app_rd_data_valid = 1'b1;
         step();
         if (j == 8) chk("t5_no_ovf_yet", 32'(err_overflow), 32'd0);
      end
      m_push = 1'b1;
      chk("t5_ovf", 32'(err_overflow), 32'd1);
      drain("t5");

      // Asynchronous reset in the middle of a beat, plus byte ordering
      do_reset();
      out_ready = 1'b1;
      cmd_issued = 1'b1;
      step();
      cmd_issued = 1'b1;
      step();
      app_rd_data = {32'h04040404, 32'h03030303, 32'h02020202, 32'h11223344};
      app_rd_data_valid = 1'b1;
      step();
      step();
`ifdef DDR2_RD_BYTESWAP_EN
      chk("t6_swap", out_data, 32'h44332211);
`else
      chk("t6_noswap", out_data, 32'h11223344);
`endif
      step();
      step();
      chk("t6_mid_valid", 32'(out_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_outst", 32'(outstanding), 32'd0);
      chk("t6_rst_credit", 32'(credit_ok), 32'd1);
      exp_q.delete();
      m_out = 0;
      step();
      reset = 1'b1;
      step();

      // Randomized traffic honouring credit
      do_reset();
      for (int c = 0; c < 800; c++) begin
         out_ready = ($urandom_range(3) != 0);
         cmd_issued = credit_ok && ($urandom_range(1) == 1);
         app_rd_data_valid = (m_out > 0) && ($urandom_range(2) == 0);
         app_rd_data = {$urandom, $urandom, $urandom, $urandom};
         step();
         chk("rnd_outst", 32'(outstanding), 32'(m_out));
      end
      for (int c = 0; c < 50 && m_out > 0; c++) begin
         out_ready = ($urandom_range(3) != 0);
         app_rd_data_valid = 1'b1;
         app_rd_data = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      drain("rnd");
      chk("rnd_outst_end", 32'(outstanding), 32'd0);
      chk("rnd_credit_end", 32'(credit_ok), 32'd1);
      chk("rnd_errs", {30'd0, err_overflow, err_underflow}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
